// File: rtl/exu_mcyc.sv
// exu_mcyc: multi-cycle execute stage with valid/ready both sides,
// iterative RV32M mul/div, flush and registered jump resolution.
// Ports: i_sys_clk/i_sys_rst clock and sync reset; i_exu_flush abort;
//   i_idu_* / o_idu_ready upstream op, operands, jump info; i_ifu_pc;
//   o_exu_* / i_wbu_ready downstream result, zero, jump, busy.
// Option: EXU_MUL_FAST_EN selects a one-cycle combinational multiply.
module exu_mcyc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_exu_flush,
  input  logic                  i_idu_valid,
  output logic                  o_idu_ready,
  input  logic [ADDR_WIDTH-1:0] i_ifu_pc,
  input  logic [OP_WIDTH-1:0]   i_idu_op,
  input  logic [1:0]            i_idu_jmp_type,
  input  logic [DATA_WIDTH-1:0] i_idu_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_idu_rs2_data,
  input  logic [DATA_WIDTH-1:0] i_idu_jmp_or_reg_data,
  output logic                  o_exu_valid,
  input  logic                  i_wbu_ready,
  output logic [DATA_WIDTH-1:0] o_exu_res,
  output logic                  o_exu_zero,
  output logic                  o_exu_jmp_en,
  output logic [ADDR_WIDTH-1:0] o_exu_jmp_pc,
  output logic                  o_exu_busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef logic [OP_WIDTH-1:0] op_t;
  localparam op_t OP_ADD   = op_t'(0);
  localparam op_t OP_SUB   = op_t'(1);
  localparam op_t OP_SLT   = op_t'(2);
  localparam op_t OP_SLTU  = op_t'(3);
  localparam op_t OP_MUL   = op_t'(4);
  localparam op_t OP_MULH  = op_t'(5);
  localparam op_t OP_MULHU = op_t'(6);
  localparam op_t OP_DIV   = op_t'(7);
  localparam op_t OP_DIVU  = op_t'(8);
  localparam op_t OP_REM   = op_t'(9);
  localparam op_t OP_REMU  = op_t'(10);

  localparam logic [1:0] JT_NONE = 2'd0;
  localparam logic [1:0] JT_J    = 2'd1;
  localparam logic [1:0] JT_B    = 2'd2;
  localparam logic [1:0] JT_E    = 2'd3;

  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_n;

  logic [W-1:0]          a, b;
  logic                  is_add, is_sub, is_slt, is_sltu;
  logic                  is_mul, is_mulh, is_mulhu;
  logic                  is_div, is_divu, is_rem, is_remu;
  logic                  in_mul, in_div, md, sgn_in;
  logic                  div0, ovf, in_iter, neg_in;
  logic [W-1:0]          abs_a, abs_b;
  logic [W-1:0]          one_res;
  logic                  one_jen;
  logic [ADDR_WIDTH-1:0] one_jpc;

  logic                  idu_ready, accept;
  logic                  load_one, load_iter, step, fin, clr;

  logic [W-1:0]          res_q;
  logic                  jen_q;
  logic [ADDR_WIDTH-1:0] jpc_q;
  logic [CW-1:0]         cnt;
  logic [W-1:0]          hi, lo, y;
  op_t                   op_q;
  logic                  neg_q;

  logic                  q_mul, last;
  logic [W:0]            mul_sum, div_sh, div_df;
  logic [W-1:0]          hi_n, lo_n, q_fix, r_fix;
  logic [2*W-1:0]        prod, sprod;
  logic [W-1:0]          fin_res;

  assign a = i_idu_rs1_data;
  assign b = i_idu_rs2_data;

  assign is_add   = i_idu_op == OP_ADD;
  assign is_sub   = i_idu_op == OP_SUB;
  assign is_slt   = i_idu_op == OP_SLT;
  assign is_sltu  = i_idu_op == OP_SLTU;
  assign is_mul   = i_idu_op == OP_MUL;
  assign is_mulh  = i_idu_op == OP_MULH;
  assign is_mulhu = i_idu_op == OP_MULHU;
  assign is_div   = i_idu_op == OP_DIV;
  assign is_divu  = i_idu_op == OP_DIVU;
  assign is_rem   = i_idu_op == OP_REM;
  assign is_remu  = i_idu_op == OP_REMU;

  assign in_mul = is_mul | is_mulh | is_mulhu;
  assign in_div = is_div | is_divu | is_rem | is_remu;
  assign md     = in_mul | in_div;
  assign sgn_in = is_mul | is_mulh | is_div | is_rem;

  assign div0 = b == '0;
  assign ovf  = (is_div | is_rem) & (a == MIN) & (&b);

`ifdef EXU_MUL_FAST_EN
  logic [2*W-1:0] ax, bx, fprod;
  assign ax = is_mulhu ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
  assign bx = is_mulhu ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
  assign fprod = ax * bx;
  assign in_iter = in_div & ~div0 & ~ovf;
`else
  assign in_iter = in_mul | (in_div & ~div0 & ~ovf);
`endif

  // Magnitudes feed the unsigned engine; sign is restored at the end.
  assign abs_a  = (sgn_in & a[W-1]) ? -a : a;
  assign abs_b  = (sgn_in & b[W-1]) ? -b : b;
  assign neg_in = is_rem ? a[W-1]
                : ((is_mul | is_mulh | is_div) & (a[W-1] ^ b[W-1]));

  always_comb begin
    one_res = '0;
    unique case (1'b1)
      is_add:  one_res = a + b;
      is_sub:  one_res = a - b;
      is_slt:  one_res = W'($signed(a) < $signed(b));
      is_sltu: one_res = W'(a < b);
`ifdef EXU_MUL_FAST_EN
      is_mul:  one_res = fprod[W-1:0];
      is_mulh, is_mulhu: one_res = fprod[2*W-1:W];
`endif
      // Overflow case: quotient is A (== MIN), remainder 0.
      is_div, is_divu: one_res = div0 ? '1 : a;
      is_rem, is_remu: one_res = div0 ? a : '0;
      default: one_res = '0;
    endcase
  end

  always_comb begin
    one_jen = 1'b0;
    one_jpc = '0;
    if (!md) begin
      unique case (i_idu_jmp_type)
        JT_NONE: begin end
        JT_J: begin
          one_jen = 1'b1;
          one_jpc = one_res[ADDR_WIDTH-1:0];
        end
        JT_B: begin
          if (one_res == W'(1)) begin
            one_jen = 1'b1;
            one_jpc = i_ifu_pc
                    + i_idu_jmp_or_reg_data[ADDR_WIDTH-1:0];
          end
        end
        JT_E: one_jen = 1'b1;
      endcase
    end
  end

  // Shared engine: mul keeps {hi,lo} as the shifting product,
  // div keeps hi as partial remainder and lo as dividend/quotient.
  assign q_mul = (op_q == OP_MUL) | (op_q == OP_MULH)
               | (op_q == OP_MULHU);
  assign last  = cnt == CW'(W - 1);

  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, y} : '0);
  assign div_sh  = {hi, lo[W-1]};
  assign div_df  = div_sh - {1'b0, y};

  assign hi_n = q_mul ? mul_sum[W:1]
              : (div_df[W] ? div_sh[W-1:0] : div_df[W-1:0]);
  assign lo_n = q_mul ? {mul_sum[0], lo[W-1:1]}
              : {lo[W-2:0], ~div_df[W]};

  assign prod  = {hi_n, lo_n};
  assign sprod = neg_q ? -prod : prod;
  assign q_fix = neg_q ? -lo_n : lo_n;
  assign r_fix = neg_q ? -hi_n : hi_n;

  always_comb begin
    fin_res = r_fix;
    unique case (1'b1)
      op_q == OP_MUL: fin_res = sprod[W-1:0];
      (op_q == OP_MULH) | (op_q == OP_MULHU):
        fin_res = sprod[2*W-1:W];
      (op_q == OP_DIV) | (op_q == OP_DIVU): fin_res = q_fix;
      default: fin_res = r_fix;
    endcase
  end

  assign accept = i_idu_valid & idu_ready;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n   = state;
    idu_ready = 1'b0;
    load_one  = 1'b0;
    load_iter = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: idu_ready = 1'b1;
      BUSY: begin
        step = 1'b1;
        if (last) begin
          fin     = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        idu_ready = i_wbu_ready;
        if (i_wbu_ready) begin
          state_n = IDLE;
          clr     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (accept) begin
      clr = 1'b0;
      if (in_iter) begin
        load_iter = 1'b1;
        state_n   = BUSY;
      end else begin
        load_one = 1'b1;
        state_n  = DONE;
      end
    end
    if (i_exu_flush) begin
      state_n   = IDLE;
      load_one  = 1'b0;
      load_iter = 1'b0;
      step      = 1'b0;
      fin       = 1'b0;
      clr       = 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      res_q <= '0;
      jen_q <= 1'b0;
      jpc_q <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      y     <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
    end else begin
      if (clr) begin
        res_q <= '0;
        jen_q <= 1'b0;
        jpc_q <= '0;
        cnt   <= '0;
      end
      if (load_one) begin
        res_q <= one_res;
        jen_q <= one_jen;
        jpc_q <= one_jpc;
      end
      if (load_iter) begin
        res_q <= '0;
        jen_q <= 1'b0;
        jpc_q <= '0;
        cnt   <= '0;
        hi    <= '0;
        lo    <= abs_a;
        y     <= abs_b;
        op_q  <= i_idu_op;
        neg_q <= neg_in;
      end
      if (step) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + CW'(1);
      end
      if (fin) res_q <= fin_res;
    end
  end

  assign o_idu_ready  = idu_ready;
  assign o_exu_valid  = state == DONE;
  assign o_exu_busy   = state == BUSY;
  assign o_exu_res    = res_q;
  assign o_exu_zero   = (state == DONE) & ~|res_q;
  assign o_exu_jmp_en = jen_q;
  assign o_exu_jmp_pc = jpc_q;

endmodule

// File: doc/exu_mcyc.md
Name: exu_mcyc

Overview:
- Parametrised multi-cycle execute stage; successor to the single-cycle execute block.
- Adds registered valid/ready handshakes both sides, iterative RV32M multiply/divide, flush, and width parameters.
- Sits between IDU (upstream) and WBU/LSU (downstream); branch/jump resolution is registered alongside the result.

Parameters:
- DATA_WIDTH, 32, operand/result width (even, >=8).
- ADDR_WIDTH, 32, PC width (<= DATA_WIDTH).
- OP_WIDTH, 4, opcode width.

Ports:
- i_sys_clk  in  1  clock.
- i_sys_rst  in  1  reset, synchronous, active-high; one clock, all state on rising edge.
- i_exu_flush  in  1  abort in-flight op, drop output.
- i_idu_valid  in  1  upstream op valid.
- o_idu_ready  out  1  stage can accept.
- i_ifu_pc  in  ADDR_WIDTH  PC of op.
- i_idu_op  in  OP_WIDTH  0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 MUL, 5 MULH, 6 MULHU, 7 DIV, 8 DIVU, 9 REM, 10 REMU; others give result 0.
- i_idu_jmp_type  in  2  0 NONE, 1 J, 2 B, 3 E.
- i_idu_rs1_data  in  DATA_WIDTH  operand A.
- i_idu_rs2_data  in  DATA_WIDTH  operand B.
- i_idu_jmp_or_reg_data  in  DATA_WIDTH  branch offset.
- o_exu_valid  out  1  result valid.
- i_wbu_ready  in  1  downstream accepts.
- o_exu_res  out  DATA_WIDTH  result.
- o_exu_zero  out  1  result == 0.
- o_exu_jmp_en  out  1  redirect.
- o_exu_jmp_pc  out  ADDR_WIDTH  redirect target.
- o_exu_busy  out  1  iterative op in progress.

Behaviour:
- FSM states IDLE, BUSY, DONE. Reset: IDLE; all outputs 0; o_idu_ready 1.
- o_idu_ready = (IDLE) or (DONE and i_wbu_ready); 0 in BUSY.
- Accept = i_idu_valid and o_idu_ready; operands, op, jmp type and PC are captured on accept.
- Single-cycle ops (0-3, undefined): accept -> DONE next cycle; latency 1.
- MUL/MULH/MULHU: radix-2 shift-add on absolute values, sign fixed at end; BUSY for DATA_WIDTH cycles, then DONE; latency DATA_WIDTH+1. MULH is signed x signed; MULHU is unsigned.
- DIV/DIVU/REM/REMU: restoring divide, DATA_WIDTH iterations, same latency as MUL. Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Divide by zero: quotient all ones, remainder = A; latency 1 (no BUSY).
- Signed overflow (A = 1 followed by DATA_WIDTH-1 zeros, B = all ones): DIV gives A; REM gives 0; latency 1.
- o_exu_busy = 1 exactly while in BUSY.
- DONE: o_exu_valid 1; outputs held stable while i_wbu_ready = 0.
- DONE and i_wbu_ready: output retires. If a new op is accepted in the same cycle (back-to-back), next state follows the new op; otherwise IDLE with o_exu_valid 0.
- Jump resolution uses the final result:
  - J: en = 1, pc = res[ADDR_WIDTH-1:0].
  - B: en = (res == 1), pc = pc + offset (truncated, wraps), else pc = 0.
  - E: en = 1, pc = 0.
  - NONE: en = 0, pc = 0.
  - jmp_type != NONE with op 4-10: en = 0.
- Flush: any state -> IDLE next cycle; o_exu_valid 0, outputs 0; an op accepted in the same cycle is discarded. Flush has priority over i_wbu_ready.
- Reset mid-operation: same as flush; iteration counter cleared.
- SLT is signed compare; SLTU unsigned; result is 0 or 1. ADD/SUB wrap modulo 2^DATA_WIDTH.

Optional Feature:
- EXU_MUL_FAST_EN defined: MUL/MULH/MULHU use a single-cycle combinational 2*DATA_WIDTH product; latency 1, no BUSY.
- Not defined: iterative multiply as above. Divide is always iterative.

Test Plan:
- Reset, then ADD A=5, B=7 -> one cycle later o_exu_valid=1, res=12, zero=0, busy never high.
- MUL A=0xFFFFFFFF, B=2 (signed): MUL res=0xFFFFFFFE; MULH res=0xFFFFFFFF; MULHU res=0x00000001. Valid after 33 cycles (after 1 cycle with EXU_MUL_FAST_EN).
- DIV A=-7, B=2 -> res=0xFFFFFFFD after 33 cycles; REM -> 0xFFFFFFFF; DIVU A=7, B=0 -> 0xFFFFFFFF after 1 cycle; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- SLT A=3, B=5, jmp B, pc=0x100, offset=0x20 -> jmp_en=1, jmp_pc=0x120. SLT A=5, B=3 -> jmp_en=0, jmp_pc=0.
- Hold i_wbu_ready=0 for 4 cycles in DONE -> outputs stable, o_idu_ready=0. Then assert ready with i_idu_valid=1 -> back-to-back accept, no bubble.
- Assert i_exu_flush at BUSY cycle 10 of a DIV -> next cycle IDLE, valid=0, ready=1. Repeat with i_sys_rst instead -> same.
